// File: rtl/pc_seq.sv
// Registered program-counter sequencer: condition evaluation, PC-relative and
// register branch targets, stall/halt handling and a circular return-address stack.
module pc_seq #(
    parameter int              WIDTH     = 16,
    parameter int              OFF_W     = 9,
    parameter int              RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid,
    input  logic                           stall,
    input  logic [3:0]                     opcode,
    input  logic [2:0]                     cond,
    input  logic [OFF_W-1:0]               imm,
    input  logic [WIDTH-1:0]               reg_target,
    input  logic [2:0]                     flags,
    input  logic                           link,
    input  logic                           ret,
    output logic [WIDTH-1:0]               pc,
    output logic                           taken,
    output logic                           halted,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             taken_q, taken_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic             ras_err_q, ras_err_d;
    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;
    logic [WIDTH-1:0] ras_wdata;

    logic             flag_z, flag_v, flag_n;
    logic             cond_true;
    logic             is_b, is_br, is_hlt, en;
    logic             ras_empty, ras_full, do_pop, do_push;
    logic [WIDTH-1:0] seq, imm_sext, ras_top, b_target, br_target, target;

    // Condition decode and branch target selection; ras_ptr_q names the next free slot.
    always_comb begin
        flag_z = flags[2];
        flag_v = flags[1];
        flag_n = flags[0];
        unique case (cond)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~(flag_z | flag_n);
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = ~flag_n;
            3'b101:  cond_true = flag_z | flag_n;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase

        is_b   = (opcode == OP_B);
        is_br  = (opcode == OP_BR);
        is_hlt = (opcode == OP_HLT);
        en     = valid & (is_b | is_br) & cond_true;

        seq       = pc_q + WIDTH'(2);
        imm_sext  = WIDTH'(signed'(imm));
        b_target  = seq + (imm_sext << 1);
        ras_empty = (ras_cnt_q == '0);
        ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
        ras_top   = ras_mem_q[ras_ptr_q - PTR_W'(1)];
        br_target = (ret && !ras_empty) ? ras_top : reg_target;
        target    = is_b ? b_target : br_target;
        do_pop    = is_br & ret;
        do_push   = link;
    end

    // Next-state selection in priority order: halted, stall, halt request, branch, sequential.
    always_comb begin
        pc_d      = pc_q;
        taken_d   = taken_q;
        halted_d  = halted_q;
        ras_cnt_d = ras_cnt_q;
        ras_ptr_d = ras_ptr_q;
        ras_err_d = ras_err_q;
        ras_we    = 1'b0;
        ras_waddr = ras_ptr_q;
        ras_wdata = seq;

        if (!halted_q) begin
            if (stall) begin
                taken_d = 1'b0;
            end else if (valid && is_hlt) begin
                halted_d = 1'b1;
                taken_d  = 1'b0;
            end else if (en) begin
                pc_d    = target;
                taken_d = 1'b1;
                if (do_pop && do_push) begin
                    ras_we = 1'b1;
                    if (ras_empty) begin
                        ras_err_d = 1'b1;
                        ras_ptr_d = ras_ptr_q + PTR_W'(1);
                        ras_cnt_d = CNT_W'(1);
                    end else begin
                        ras_waddr = ras_ptr_q - PTR_W'(1);
                    end
                end else if (do_pop) begin
                    if (ras_empty) begin
                        ras_err_d = 1'b1;
                    end else begin
                        ras_ptr_d = ras_ptr_q - PTR_W'(1);
                        ras_cnt_d = ras_cnt_q - CNT_W'(1);
                    end
                end else if (do_push) begin
                    // A push onto a full stack lands on the oldest slot, which is the free-slot pointer.
                    ras_we    = 1'b1;
                    ras_ptr_d = ras_ptr_q + PTR_W'(1);
                    if (ras_full) begin
                        ras_err_d = 1'b1;
                    end else begin
                        ras_cnt_d = ras_cnt_q + CNT_W'(1);
                    end
                end
            end else begin
                pc_d    = seq;
                taken_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            taken_q   <= 1'b0;
            halted_q  <= 1'b0;
            ras_cnt_q <= '0;
            ras_ptr_q <= '0;
            ras_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            taken_q   <= taken_d;
            halted_q  <= halted_d;
            ras_cnt_q <= ras_cnt_d;
            ras_ptr_q <= ras_ptr_d;
            ras_err_q <= ras_err_d;
        end
    end

    // Stack entries survive reset; only the count and pointer are cleared.
    always_ff @(posedge clk) begin
        if (ras_we && !rst) begin
            ras_mem_q[ras_waddr] <= ras_wdata;
        end
    end

    assign pc        = pc_q;
    assign taken     = taken_q;
    assign halted    = halted_q;
    assign ras_count = ras_cnt_q;
    assign ras_err   = ras_err_q;

endmodule

// File: doc/pc_seq.md
# pc_seq

Registered program-counter sequencer for the fetch stage, generalising the combinational PC-select logic into a parametrised, clocked unit. Holds the architectural PC, evaluates branch conditions against the {Z,V,N} flags, computes PC-relative and register targets, and stalls or halts. Adds a circular return-address stack (RAS) for linked branches and returns. Sits between the flag register/decoder and the instruction-memory address port.

## Interface
- WIDTH, 16: PC and target width.
- OFF_W, 9: branch immediate width; sign-extended, then shifted left 1.
- RAS_DEPTH, 4: return-address stack entries; power of two, at least 2.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  decoded instruction fields are meaningful this cycle.
- stall  in  1  hold the PC and all state.
- opcode  in  4  1100 = B (PC-relative), 1101 = BR (register), 1111 = HLT; any other value is sequential.
- cond  in  3  branch condition code.
- imm  in  OFF_W  B offset, in instruction units.
- reg_target  in  WIDTH  BR target.
- flags  in  3  {Z,V,N}.
- link  in  1  on a taken B/BR, push PC+2 onto the RAS.
- ret  in  1  on a taken BR, pop the RAS and use it as the target.
- pc  out  WIDTH  current PC (registered).
- taken  out  1  registered; high for the cycle after a taken branch.
- halted  out  1  sticky halt indicator.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid entries.
- ras_err  out  1  sticky; set on RAS overflow or underflow.

## Operation
- Condition codes:
  - 000: ~Z
  - 001: Z
  - 010: ~(Z|N)
  - 011: N
  - 100: ~N
  - 101: Z|N
  - 110: V
  - 111: always
- en = valid & (opcode is B or BR) & cond_true.
- seq = pc + 2. All adds are modulo 2^WIDTH; wrap-around is silent.
- B target = seq + (sext(imm) << 1).
- BR target:
  - ret=1 and RAS non-empty: RAS top.
  - Otherwise: reg_target.
- Next-state priority, highest first:
  1. rst
  2. halted: hold everything.
  3. stall: hold everything; taken goes to 0.
  4. valid & HLT: PC holds; halted is set.
  5. en: PC = target; taken = 1.
  6. Otherwise: PC = seq; taken = 0.
- HLT while stall=1 is ignored until stall drops.
- RAS is updated only when en=1 and stall=0:
  - Pop when opcode=BR and ret=1.
  - Push seq when link=1.
  - Pop and push in the same cycle: the top entry is replaced by seq; count unchanged.
  - Push when full: the write overwrites the oldest entry (circular); count stays at RAS_DEPTH; ras_err is set.
  - Pop when empty: target is reg_target; count stays 0; ras_err is set.
  - ret or link on a not-taken branch or non-branch: no RAS effect.
- RAS storage is a circular array with a top pointer. Entries are not cleared by reset; only the count and pointer are.
- Reset values:
  - pc = RESET_PC
  - taken = 0
  - halted = 0
  - ras_count = 0
  - ras_err = 0
  - RAS pointer = 0

## Timing
- Single-cycle latency: inputs sampled at edge N determine pc, taken, and RAS state visible after edge N.
- Target and condition evaluation are combinational from inputs and current pc and RAS top. No combinational path from any input to any output.
- rst asserted mid-operation overrides stall, halted, and a simultaneous branch; all outputs take their reset values on that edge.
- halted clears only by rst.
- A RAS push at edge N is visible to a ret at edge N+1 with no bypass hazard.

## Test plan
- Reset, then 3 cycles with valid=0 and stall=0 → pc = 0, 2, 4, 6; taken stays 0.
- pc = 0x0010, B, cond=001, Z=1, imm=0x1FE (−2) → next pc = 0x0012 − 4 = 0x000E, taken=1. Same with Z=0 → pc = 0x0012, taken=0.
- Sweep all 8 cond codes × 8 flag combinations with BR, reg_target=0xBEEF → pc = 0xBEEF exactly when the condition-code list above is true, else pc+2.
- Call/return, RAS_DEPTH=4:
  - B link at pc 0x0100 → RAS top = 0x0102, ras_count=1.
  - BR ret with cond=111 → pc = 0x0102, count=0.
  - Five consecutive pushes → count=4, ras_err=1; four pops return the last four pushed values.
  - A further pop → pc = reg_target.
- stall held 3 cycles during a taken B → pc frozen, no RAS change; the branch executes on the first non-stall cycle. HLT → halted=1 and pc frozen despite later branches; rst mid-halt → pc = RESET_PC, halted = 0.
- pc = 0xFFFE, sequential → pc = 0x0000. B with imm=0x0FF from 0xFFF0 → pc = 0xFFF2 + 0x1FE wrapped = 0x01F0.
